// File: rtl/regfile_write_scheduler_pkg.sv
// Shared widths and constants for the register-file write scheduler.
// Register 0 is architecturally zero, so it is never written or reserved.
package regfile_write_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational, 0 cycles; one-hot grant to the first request after ptr.
// No backpressure of its own; grant is zero when no request is raised.
module rr_arbiter
  import regfile_write_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_vld
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    // Search starts one past the last winner so it becomes lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_vld && req[idx]) begin
        grant_vld      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates writeback sources onto the single regfile write port; write port latency 1 cycle.
// Sources wait on req_ready (one grant per cycle); decode is held off via stall/issue_ready.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_reg,
  output logic                          issue_ready,
  input  logic [REG_ADDR_W-1:0]         read1,
  input  logic [REG_ADDR_W-1:0]         read2,
  output logic                          stall,
  input  logic                          flush,
  output logic                          regWrite,
  output logic [REG_ADDR_W-1:0]         writeReg,
  output logic [DATA_W-1:0]             writeData
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] writereg_q, writereg_d;
  logic [DATA_W-1:0]     writedata_q, writedata_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  logic [NUM_REQ-1:0]    grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic                  transfer;
  logic                  reserve;
  logic [REG_ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0]     win_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    req_ready = reset ? '0 : grant;
    transfer  = grant_vld & ~reset;
    win_reg   = req_reg[grant_idx*REG_ADDR_W +: REG_ADDR_W];
    win_data  = req_data[grant_idx*DATA_W +: DATA_W];
  end

  always_comb begin
    ptr_d       = transfer ? grant_idx : ptr_q;
    regwrite_d  = transfer && (win_reg != REG_ZERO);
    writereg_d  = transfer ? win_reg : writereg_q;
    writedata_d = transfer ? win_data : writedata_q;
  end

  // Readiness looks at the pre-clear scoreboard, so a same-cycle clear+reserve of r is refused.
  always_comb begin
    issue_ready = ~flush & ((issue_reg == REG_ZERO) | ~pending_q[issue_reg]);
    reserve     = issue_valid & issue_ready & (issue_reg != REG_ZERO);
    stall       = ((read1 != REG_ZERO) & pending_q[read1]) |
                  ((read2 != REG_ZERO) & pending_q[read2]);
  end

  always_comb begin
    pending_d = pending_q;
    if (transfer) begin
      pending_d[win_reg] = 1'b0;
    end
    if (reserve) begin
      pending_d[issue_reg] = 1'b1;
    end
    if (flush) begin
      pending_d = '0;
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= PTR_W'(NUM_REQ - 1);
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
      pending_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      pending_q   <= pending_d;
    end
  end

  assign regWrite  = regwrite_q;
  assign writeReg  = writereg_q;
  assign writeData = writedata_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed-vector bench for regfile_write_scheduler; expected values are hand-derived.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        issue_ready;
  logic [4:0]  read1;
  logic [4:0]  read2;
  logic        stall;
  logic        flush;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler #(.NUM_REQ(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_reg     (req_reg),
    .req_data    (req_data),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .issue_ready (issue_ready),
    .read1       (read1),
    .read2       (read2),
    .stall       (stall),
    .flush       (flush),
    .regWrite    (regWrite),
    .writeReg    (writeReg),
    .writeData   (writeData)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 3'b111;
    req_reg     = {5'd10, 5'd9, 5'd8};
    req_data    = {32'hCCCC_0010, 32'hBBBB_0009, 32'hAAAA_0008};
    issue_valid = 1'b0;
    issue_reg   = 5'd0;
    read1       = 5'd8;
    read2       = 5'd0;
    flush       = 1'b0;
    tick();
    tick();
    #4;
    check("rst_ready", req_ready, 3'b000);
    check("rst_we", regWrite, 1'b0);
    check("rst_wreg", writeReg, 5'd0);
    check("rst_wdata", writeData, 32'h0);
    check("rst_stall", stall, 1'b0);

    // 1) all three requesting: 0,1,2,0
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #4;
      check("t1_grant", req_ready, 32'(1 << (k % 3)));
      tick();
      check("t1_we", regWrite, 1'b1);
      check("t1_wreg", writeReg, 32'(8 + (k % 3)));
    end
    check("t1_wdata", writeData, 32'hAAAA_0008);
    req_valid = 3'b000;

    // 2) reserve 8, stall, clear by transfer from requester 1
    issue_valid = 1'b1;
    issue_reg   = 5'd8;
    read1       = 5'd0;
    #4;
    check("t2_issue_ok", issue_ready, 1'b1);
    tick();
    check("t2_we_idle", regWrite, 1'b0);
    issue_valid = 1'b0;
    read1       = 5'd8;
    #4;
    check("t2_stall", stall, 1'b1);
    check("t2_issue_blk", issue_ready, 1'b0);
    tick();
    req_valid   = 3'b010;
    req_reg     = {5'd10, 5'd8, 5'd8};
    req_data    = {32'hCCCC_0010, 32'h1234_5678, 32'hAAAA_0008};
    issue_valid = 1'b1;
    #4;
    check("t2_grant1", req_ready, 3'b010);
    check("t2_stall_same", stall, 1'b1);
    check("t2_clr_rsv", issue_ready, 1'b0);
    tick();
    req_valid = 3'b000;
    #4;
    check("t2_stall_drop", stall, 1'b0);
    check("t2_issue_again", issue_ready, 1'b1);
    check("t2_we", regWrite, 1'b1);
    check("t2_wdata", writeData, 32'h1234_5678);
    tick();
    issue_valid = 1'b0;
    #4;
    check("t2_rsv_again", stall, 1'b1);

    // 3) write to register 0
    tick();
    req_valid   = 3'b001;
    req_reg     = {5'd10, 5'd9, 5'd0};
    req_data    = {32'hCCCC_0010, 32'hBBBB_0009, 32'hDEAD_BEEF};
    issue_valid = 1'b1;
    issue_reg   = 5'd0;
    read1       = 5'd0;
    read2       = 5'd0;
    #4;
    check("t3_grant0", req_ready, 3'b001);
    check("t3_issue_r0", issue_ready, 1'b1);
    check("t3_stall_r0", stall, 1'b0);
    tick();
    req_valid   = 3'b000;
    issue_valid = 1'b0;
    #4;
    check("t3_we_r0", regWrite, 1'b0);
    check("t3_stall_r0b", stall, 1'b0);

    // 4) reserve 5,6,7 then flush alongside a reserve of 9
    for (int k = 5; k <= 7; k++) begin
      tick();
      issue_valid = 1'b1;
      issue_reg   = 5'(k);
    end
    tick();
    issue_reg = 5'd9;
    flush     = 1'b1;
    read1     = 5'd5;
    read2     = 5'd9;
    #4;
    check("t4_flush_rdy", issue_ready, 1'b0);
    check("t4_pre_stall", stall, 1'b1);
    tick();
    flush       = 1'b0;
    issue_valid = 1'b0;
    #4;
    check("t4_post_stall", stall, 1'b0);
    read1 = 5'd8;
    read2 = 5'd7;
    #1;
    check("t4_all_clear", stall, 1'b0);

    // 5) requester 2 alone, then all three
    tick();
    read1     = 5'd0;
    read2     = 5'd0;
    req_reg   = {5'd10, 5'd9, 5'd8};
    req_data  = {32'hCCCC_0010, 32'hBBBB_0009, 32'hAAAA_0008};
    req_valid = 3'b100;
    for (int k = 0; k < 4; k++) begin
      #4;
      check("t5_solo", req_ready, 3'b100);
      tick();
      check("t5_solo_wreg", writeReg, 5'd10);
    end
    req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #4;
      check("t5_rr", req_ready, 32'(1 << k));
      tick();
      check("t5_rr_wreg", writeReg, 32'(8 + k));
    end

    // 6) reset while a grant is live
    req_valid   = 3'b001;
    issue_valid = 1'b1;
    issue_reg   = 5'd12;
    tick();
    issue_valid = 1'b0;
    req_valid   = 3'b111;
    read1       = 5'd12;
    #4;
    check("t6_pre_grant", req_ready, 3'b010);
    check("t6_pre_stall", stall, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_rst_ready", req_ready, 3'b000);
    tick();
    reset = 1'b0;
    #3;
    check("t6_we", regWrite, 1'b0);
    check("t6_wreg", writeReg, 5'd0);
    check("t6_stall", stall, 1'b0);
    check("t6_restart", req_ready, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
